// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave ACK engine: FSM state encoding,
// SDA drive levels for the ACK slot, and default sizing.
package i2c_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic SDA_ACK  = 1'b0;
    localparam logic SDA_NACK = 1'b1;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BYTES = 16;

endpackage

// File: rtl/i2c_slave_rx_shifter.sv
// Receive shift register and bit counter for one byte slot. The counter
// runs only while shifting is enabled and wraps to zero on the last bit,
// so it is always zero when the byte's ACK slot begins.
module i2c_slave_rx_shifter
    import i2c_slave_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_shift_en,
    input  logic              i_capture,
    input  logic              i_sda,
    output logic [DATA_W-1:0] o_shreg,
    output logic              o_last_bit
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              w_last;

    assign w_last     = (r_bit_cnt == LAST_BIT);
    assign o_last_bit = w_last;
    assign o_shreg    = r_shreg;

    // Bit position within the byte; cleared outside SHIFT and after the last bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt <= '0;
        end else if (!i_shift_en || w_last) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Data path: SDA enters at the LSB so the first bit ends up as the MSB.
    always_ff @(posedge CLK) begin
        if (i_capture) begin
            r_shreg <= {r_shreg[DATA_W-2:0], i_sda};
        end
    end

endmodule

// File: rtl/i2c_slave_ack_engine.sv
// I2C slave ACK engine: counts byte slots, decides ACK/NACK for written
// bytes, watches the master's ACK on reads, and publishes received bytes.
// All outputs are registered; enable low aborts the transaction at once.
module i2c_slave_ack_engine
    import i2c_slave_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BYTES = DEF_MAX_BYTES,
    parameter int CNT_W     = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              rw,
    input  logic              sda_in,
    input  logic              rx_ready,
    output logic              sda_o,
    output logic              outing_ack,
    output logic              done_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [CNT_W-1:0]  byte_count,
    output logic              nack_flag
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    // Byte counter increment that sticks at MAX_BYTES instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= MAX_CNT) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    state_t            r_state, w_state_nxt;
    logic              r_rw, w_rw_nxt;
    logic              r_sda, w_sda_nxt;
    logic              r_outing, w_outing_nxt;
    logic              r_done, w_done_nxt;
    logic              r_rxv, w_rxv_nxt;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_nack, w_nack_nxt;

    logic              w_shift_en;
    logic              w_capture;
    logic              w_last_bit;
    logic [DATA_W-1:0] w_shreg;

    // rw is latched at transaction start, so only writes capture data bits.
    assign w_shift_en = enable && (r_state == ST_SHIFT);
    assign w_capture  = w_shift_en && !r_rw;

    i2c_slave_rx_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .CLK        (CLK),
        .RST        (RST),
        .i_shift_en (w_shift_en),
        .i_capture  (w_capture),
        .i_sda      (sda_in),
        .o_shreg    (w_shreg),
        .o_last_bit (w_last_bit)
    );

    // Next state and next registered outputs; SDA is released unless ACKing.
    always_comb begin
        w_state_nxt   = r_state;
        w_rw_nxt      = r_rw;
        w_sda_nxt     = SDA_NACK;
        w_outing_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_rxv_nxt     = 1'b0;
        w_rx_data_nxt = r_rx_data;
        w_cnt_nxt     = r_cnt;
        w_nack_nxt    = r_nack;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SHIFT;
                    w_rw_nxt    = rw;
                    w_cnt_nxt   = '0;
                    w_nack_nxt  = 1'b0;
                end
                ST_SHIFT: begin
                    if (w_last_bit) begin
                        w_state_nxt  = ST_ACK;
                        w_outing_nxt = 1'b1;
                        if (!r_rw && rx_ready && (r_cnt < MAX_CNT)) begin
                            w_sda_nxt = SDA_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    w_done_nxt = 1'b1;
                    if (!r_rw) begin
                        // The ACK/NACK we are driving this slot decides the outcome.
                        if (r_sda == SDA_ACK) begin
                            w_rx_data_nxt = w_shreg;
                            w_rxv_nxt     = 1'b1;
                            w_cnt_nxt     = sat_inc(r_cnt);
                            w_state_nxt   = ST_SHIFT;
                        end else begin
                            w_nack_nxt  = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        // On reads the master answers on SDA.
                        if (sda_in == SDA_ACK) begin
                            w_cnt_nxt   = sat_inc(r_cnt);
                            w_state_nxt = ST_SHIFT;
                        end else begin
                            w_nack_nxt  = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    w_state_nxt = ST_HOLD;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset leaves SDA released.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_rw      <= 1'b0;
            r_sda     <= SDA_NACK;
            r_outing  <= 1'b0;
            r_done    <= 1'b0;
            r_rxv     <= 1'b0;
            r_rx_data <= '0;
            r_cnt     <= '0;
            r_nack    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rw      <= w_rw_nxt;
            r_sda     <= w_sda_nxt;
            r_outing  <= w_outing_nxt;
            r_done    <= w_done_nxt;
            r_rxv     <= w_rxv_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_cnt     <= w_cnt_nxt;
            r_nack    <= w_nack_nxt;
        end
    end

    assign sda_o      = r_sda;
    assign outing_ack = r_outing;
    assign done_ack   = r_done;
    assign rx_valid   = r_rxv;
    assign rx_data    = r_rx_data;
    assign byte_count = r_cnt;
    assign nack_flag  = r_nack;

endmodule

// File: tb/tb_i2c_slave_ack_engine.sv
// Self-checking bench for i2c_slave_ack_engine: a cycle table for a single
// written byte, directed multi-cycle corner cases, then randomized traffic
// compared against a transaction-level reference model.
module tb_i2c_slave_ack_engine;
    import i2c_slave_pkg::*;

    localparam int DW  = 8;
    localparam int MB  = 16;
    localparam int CW  = 5;
    localparam int MB2 = 2;
    localparam int CW2 = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic enable = 1'b0, rw = 1'b0, sda_in = 1'b0, rx_ready = 1'b0;

    logic          sda_o, outing_ack, done_ack, rx_valid, nack_flag;
    logic [DW-1:0] rx_data;
    logic [CW-1:0] byte_count;

    logic           d2_sda_o, d2_outing_ack, d2_done_ack, d2_rx_valid, d2_nack_flag;
    logic [DW-1:0]  d2_rx_data;
    logic [CW2-1:0] d2_byte_count;

    i2c_slave_ack_engine #(.DATA_W(DW), .MAX_BYTES(MB), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .rw(rw), .sda_in(sda_in),
        .rx_ready(rx_ready), .sda_o(sda_o), .outing_ack(outing_ack),
        .done_ack(done_ack), .rx_data(rx_data), .rx_valid(rx_valid),
        .byte_count(byte_count), .nack_flag(nack_flag)
    );

    i2c_slave_ack_engine #(.DATA_W(DW), .MAX_BYTES(MB2), .CNT_W(CW2)) dut2 (
        .CLK(CLK), .RST(RST), .enable(enable), .rw(rw), .sda_in(sda_in),
        .rx_ready(rx_ready), .sda_o(d2_sda_o), .outing_ack(d2_outing_ack),
        .done_ack(d2_done_ack), .rx_data(d2_rx_data), .rx_valid(d2_rx_valid),
        .byte_count(d2_byte_count), .nack_flag(d2_nack_flag)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Observed-event flags accumulated after every clock.
    bit seen_sda_low, seen_rxv, seen_done, seen_outing;

    // Reference model: transaction-level view (byte slot position, hold flag).
    int   m_active, m_hold, m_k, m_rw, m_byte;
    bit   e_sda, e_out, e_done, e_rxv, e_nack;
    logic [7:0] e_rxd;
    int   e_cnt;

    function automatic void model_reset();
        m_active = 0; m_hold = 0; m_k = 0; m_rw = 0; m_byte = 0;
        e_sda = 1'b1; e_out = 1'b0; e_done = 1'b0; e_rxv = 1'b0;
        e_nack = 1'b0; e_rxd = 8'h00; e_cnt = 0;
    endfunction

    function automatic void model_edge(input bit en, input bit r, input bit s, input bit rdy);
        bit acked;
        e_done = 1'b0;
        e_rxv  = 1'b0;
        if (!en) begin
            m_active = 0; m_hold = 0; e_sda = 1'b1; e_out = 1'b0;
        end else if (m_active == 0) begin
            m_active = 1; m_hold = 0; m_k = 0; m_rw = int'(r); m_byte = 0;
            e_cnt = 0; e_nack = 1'b0;
        end else if (m_hold != 0) begin
            m_hold = 1;
        end else if (m_k < DW) begin
            if (m_rw == 0) m_byte = ((m_byte << 1) | int'(s)) & 255;
            m_k++;
            if (m_k == DW) begin
                e_out = 1'b1;
                e_sda = (m_rw == 0 && rdy && e_cnt < MB) ? 1'b0 : 1'b1;
            end
        end else begin
            e_out  = 1'b0;
            e_done = 1'b1;
            acked  = (m_rw != 0) ? !s : !e_sda;
            e_sda  = 1'b1;
            if (acked) begin
                if (e_cnt < MB) e_cnt++;
                if (m_rw == 0) begin
                    e_rxd = 8'(m_byte);
                    e_rxv = 1'b1;
                end
                m_k = 0;
                m_byte = 0;
            end else begin
                e_nack = 1'b1;
                m_hold = 1;
            end
        end
    endfunction

    function automatic logic [31:0] obs();
        return {14'd0, sda_o, outing_ack, done_ack, rx_valid, rx_data, byte_count, nack_flag};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_model(input string nm);
        chk(nm, obs(), {14'd0, e_sda, e_out, e_done, e_rxv, e_rxd, 5'(e_cnt), e_nack});
    endtask

    // One clock: drive inputs, step the model, sample 1ns after the edge.
    task automatic cyc(input bit en, input bit r, input bit s, input bit rdy);
        enable = en; rw = r; sda_in = s; rx_ready = rdy;
        model_edge(en, r, s, rdy);
        @(posedge CLK);
        #1;
        if (sda_o == 1'b0) seen_sda_low = 1'b1;
        if (rx_valid)      seen_rxv = 1'b1;
        if (done_ack)      seen_done = 1'b1;
        if (outing_ack)    seen_outing = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit r, input bit rdy);
        for (int i = 7; i >= 0; i--) cyc(1'b1, r, b[i], rdy);
    endtask

    task automatic clear_seen();
        seen_sda_low = 1'b0; seen_rxv = 1'b0; seen_done = 1'b0; seen_outing = 1'b0;
    endtask

    typedef struct {
        bit en; bit r; bit s; bit rdy;
        bit x_sda; bit x_out; bit x_done; bit x_rxv;
        logic [7:0] x_rxd; int x_cnt; bit x_nack;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0] pat;
        int len, mode, idle;
        bit s, rdy;

        // Table: one written byte 0xA5 with rx_ready=1, then a pause and abort.
        pat = 8'hA5;
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = '{1'b1, 1'b0, pat[8-i], 1'b1, (i == 8) ? 1'b0 : 1'b1,
                       (i == 8) ? 1'b1 : 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        end
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0};

        clear_seen();
        model_reset();

        // Reset state, then a clock with enable=0 must not start anything.
        @(negedge CLK);
        chk("reset_outputs", obs(), {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0});
        chk("reset_state", 32'(dut.r_state), 32'(ST_IDLE));
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_release_idle", 32'(dut.r_state), 32'(ST_IDLE));

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].en, tbl[i].r, tbl[i].s, tbl[i].rdy);
            chk($sformatf("vec%0d", i), obs(),
                {14'd0, tbl[i].x_sda, tbl[i].x_out, tbl[i].x_done, tbl[i].x_rxv,
                 tbl[i].x_rxd, 5'(tbl[i].x_cnt), tbl[i].x_nack});
        end

        // Write with rx_ready=0: NACK, then HOLD until enable drops.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'h3C, 1'b0, 1'b0);
        chk("nack_slot", {30'd0, sda_o, outing_ack}, {30'd0, 1'b1, 1'b1});
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("nack_exit", obs(), {14'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1});
        clear_seen();
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        chk("hold_quiet", {28'd0, seen_sda_low, seen_rxv, seen_done, seen_outing}, 32'd0);
        chk("hold_state", 32'(dut.r_state), 32'(ST_HOLD));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("hold_exit", 32'(dut.r_state), 32'(ST_IDLE));

        // MAX_BYTES=2 instance: third write byte is NACKed.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(8'h11, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("max_b1_cnt", 32'(d2_byte_count), 32'd1);
        send_bits(8'h22, 1'b0, 1'b1);
        chk("max_b2_slot", {31'd0, d2_sda_o}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(8'h33, 1'b0, 1'b1);
        chk("max_b3_slot", {31'd0, d2_sda_o}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("max_b3_exit", {22'd0, d2_rx_data, d2_byte_count, d2_nack_flag},
            {22'd0, 8'h22, 2'd2, 1'b1});
        chk("big_b3_exit", obs(), {14'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 5'd3, 1'b0});
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Read: master ACKs twice then NACKs; rw toggled mid-transaction.
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        clear_seen();
        for (int b = 0; b < 3; b++) begin
            send_bits(8'($urandom), 1'b0, 1'b1);
            cyc(1'b1, 1'b0, (b == 2) ? 1'b1 : 1'b0, 1'b1);
        end
        chk("read_result", obs(), {14'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 5'd2, 1'b1});
        chk("read_no_drive", {30'd0, seen_sda_low, seen_rxv}, 32'd0);
        chk("read_state", 32'(dut.r_state), 32'(ST_HOLD));
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort after four bits of the second byte.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(8'h5A, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
        clear_seen();
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("abort_out", obs(), {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd1, 1'b0});
        chk("abort_state", 32'(dut.r_state), 32'(ST_IDLE));
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("abort_quiet", {30'd0, seen_rxv, seen_done}, 32'd0);

        // Asynchronous reset in the middle of an ACK slot.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(8'h96, 1'b0, 1'b1);
        chk("ack_slot_pre_rst", {30'd0, sda_o, outing_ack}, {30'd0, 1'b0, 1'b1});
        #2;
        RST = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_reset", obs(), {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0});
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        model_reset();

        // Randomized transactions against the reference model.
        for (int t = 0; t < 40; t++) begin
            len  = $urandom_range(1, 300);
            mode = $urandom_range(0, 2);
            for (int j = 0; j < len; j++) begin
                s   = (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                rdy = (mode == 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
                cyc(1'b1, 1'($urandom_range(0, 1)), s, rdy);
                chk_model("rand");
            end
            idle = $urandom_range(1, 3);
            for (int j = 0; j < idle; j++) begin
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
                chk_model("rand_idle");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_ack_engine.md
I2C_SLAVE_ACK_ENGINE -- requirements
Module: i2c_slave_ack_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the bits per data byte slot.
REQ-002 The block SHALL have parameter MAX_BYTES, default 16, giving the bytes ACKed per transaction before a forced NACK.
REQ-003 The block SHALL have parameter CNT_W, default 5, giving the byte_count width; it SHALL satisfy 2^CNT_W > MAX_BYTES.
REQ-004 The block SHALL have port CLK, input, 1 bit: clock (SCL); all state updates on the rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: transaction active (address matched, before STOP).
REQ-007 The block SHALL have port rw, input, 1 bit: 0 = master writes (slave ACKs), 1 = master reads (master ACKs).
REQ-008 The block SHALL have port sda_in, input, 1 bit: sampled SDA line.
REQ-009 The block SHALL have port rx_ready, input, 1 bit: downstream can accept a received byte.
REQ-010 The block SHALL have port sda_o, output, 1 bit: 0 = drive SDA low, 1 = release.
REQ-011 The block SHALL have port outing_ack, output, 1 bit: high for the whole ACK slot.
REQ-012 The block SHALL have port done_ack, output, 1 bit: one-cycle pulse on the cycle after the ACK slot.
REQ-013 The block SHALL have port rx_data, output, DATA_W bits: last received byte, MSB first.
REQ-014 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when a received byte is ACKed.
REQ-015 The block SHALL have port byte_count, output, CNT_W bits: bytes ACKed in the current transaction.
REQ-016 The block SHALL have port nack_flag, output, 1 bit: sticky; a NACK was sent or received in this transaction.

Function
REQ-017 The block SHALL implement the states IDLE, SHIFT, ACK and HOLD.
REQ-018 In IDLE with enable=1, the block SHALL move to SHIFT next edge with the bit counter at 0, byte_count at 0 and nack_flag at 0.
REQ-019 In SHIFT, each edge SHALL increment the bit counter; if rw=0, each edge SHALL also shift sda_in into the shift register LSB.
REQ-020 On the edge where the bit counter equals DATA_W-1, the block SHALL enter ACK and register sda_o.
REQ-021 When entering ACK with rw=0, sda_o SHALL be 0 (ACK) iff rx_ready=1 and byte_count < MAX_BYTES; otherwise sda_o SHALL be 1 (NACK).
REQ-022 When entering ACK with rw=1, sda_o SHALL be 1.
REQ-023 In ACK, outing_ack SHALL be 1; on the exit edge the block SHALL set sda_o=1 and done_ack=1 for exactly one cycle.
REQ-024 For rw=0 with ACK, the ACK exit edge SHALL load rx_data from the shift register, pulse rx_valid, increment byte_count and go to SHIFT.
REQ-025 For rw=0 with NACK, the ACK exit edge SHALL leave rx_data unchanged, not pulse rx_valid, set nack_flag and go to HOLD.
REQ-026 For rw=1, the ACK exit edge SHALL sample sda_in: 0 SHALL increment byte_count and go to SHIFT; 1 SHALL set nack_flag and go to HOLD.
REQ-027 In HOLD, sda_o SHALL be 1 and no counters SHALL change; the block SHALL stay in HOLD until enable=0.
REQ-028 enable=0 on any edge SHALL force IDLE, sda_o=1, outing_ack=0 and bit counter=0, including mid-byte and mid-ACK; no rx_valid or done_ack pulse SHALL result.
REQ-029 When enable=0, rx_data, byte_count and nack_flag SHALL hold their values until the next IDLE to SHIFT transition.
REQ-030 byte_count SHALL saturate at MAX_BYTES and never wrap.
REQ-031 rw SHALL be sampled only on the IDLE to SHIFT edge and held internally for the whole transaction.
REQ-032 sda_o, outing_ack, done_ack and rx_valid SHALL be register outputs, with no combinational path from inputs.

Reset
REQ-033 RST=0 SHALL asynchronously force state IDLE, sda_o=1, outing_ack=0, done_ack=0, rx_valid=0, rx_data=0, byte_count=0, nack_flag=0 and bit counter=0.
REQ-034 Release of RST SHALL take effect on the next CLK rising edge; the first transition SHALL require enable=1.

Structure
REQ-035 The state encoding, the constants SDA_ACK=0 and SDA_NACK=1, and the default DATA_W and MAX_BYTES values SHALL live in the shared package i2c_slave_pkg.
REQ-036 The shift register and bit counter SHALL be one sub-module, i2c_slave_rx_shifter; the FSM and ACK decision SHALL stay in the top module.

Verification
REQ-037 Write 0xA5 with rx_ready=1 -> sda_o=0 during the ACK slot, rx_data=0xA5, one rx_valid pulse, one done_ack pulse, byte_count=1.
REQ-038 Write with rx_ready=0 -> sda_o=1 in the ACK slot, no rx_valid, nack_flag=1, block in HOLD until enable drops.
REQ-039 MAX_BYTES=2, three write bytes -> bytes 1 and 2 ACKed; byte 3 NACKed, byte_count=2, nack_flag=1.
REQ-040 Read with master sda_in=0 in ACK slots 1 and 2 and sda_in=1 in slot 3 -> byte_count=2, nack_flag=1, sda_o stays 1 throughout, state HOLD.
REQ-041 enable dropped after bit 4 of a byte -> IDLE next edge, sda_o=1, no rx_valid, byte_count unchanged.
REQ-042 RST asserted during the ACK slot -> sda_o=1 and outing_ack=0 immediately without waiting for a clock edge; all outputs at reset values.
